// File: rtl/cache_refill_arbiter_if.sv
// Memory-side line transfer bus shared by the I- and D-cache refill paths.
//   master : arbiter drives mem_req/mem_we/mem_addr/mem_wdata, samples mem_ack/mem_rdata
//   slave  : backing memory returns mem_ack (one-cycle pulse) and mem_rdata
interface cache_refill_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cache_refill_arbiter.sv
// Arbitrates line refills and dirty write-backs for the I- and D-caches onto one
// slow backing memory: per miss an optional write-back, one fill, then a done pulse.
//   clk, reset_n         : clock, synchronous active-low reset
//   i_miss/i_addr        : I-cache refill request (level, held until i_done)
//   d_miss/d_addr        : D-cache refill request (level, held until d_done)
//   d_dirty/d_wb_addr/
//   d_wb_data            : D victim write-back info, sampled at grant
//   fill_data            : registered fill line, valid while i_done/d_done high
//   i_done/d_done        : one-cycle completion pulses
//   busy                 : high whenever not idle
//   mem                  : memory transfer bus (master side)
module cache_refill_arbiter #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned MAX_I_WAIT = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_miss,
  input  logic [15:0]                     i_addr,
  input  logic                            d_miss,
  input  logic [15:0]                     d_addr,
  input  logic                            d_dirty,
  input  logic [15:0]                     d_wb_addr,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] d_wb_data,
  output logic [WORD_SIZE*LINE_WORDS-1:0] fill_data,
  output logic                            i_done,
  output logic                            d_done,
  output logic                            busy,
  cache_refill_arbiter_if.master          mem
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = WORD_SIZE * LINE_WORDS;
  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned LA_W   = ADDR_W - OFF_W;
  localparam int unsigned SKIP_W = $clog2(MAX_I_WAIT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WB   = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [OFF_W-1:0] OFF_ZERO = '0;

  logic [1:0]        state, state_nxt;
  logic              owner_d, owner_d_nxt;
  logic [LA_W-1:0]   miss_line, miss_line_nxt;
  logic [SKIP_W-1:0] i_skip, skip_nxt;
  logic [LINE_W-1:0] fill_q, fill_nxt;
  logic              req_q, req_nxt;
  logic              we_q, we_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [LINE_W-1:0] wdata_q, wdata_nxt;
  logic              i_done_q, i_done_nxt;
  logic              d_done_q, d_done_nxt;
  logic              busy_q, busy_nxt;
  logic              grant_d, shared;

  logic [LA_W-1:0] i_line, d_line, wb_line;
  logic            skip_full;
  logic            unused_low_bits;

  assign i_line    = i_addr[ADDR_W-1:OFF_W];
  assign d_line    = d_addr[ADDR_W-1:OFF_W];
  assign wb_line   = d_wb_addr[ADDR_W-1:OFF_W];
  assign skip_full = (i_skip == SKIP_W'(MAX_I_WAIT));
  assign unused_low_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0], d_wb_addr[OFF_W-1:0]};

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt     = state;
    owner_d_nxt   = owner_d;
    miss_line_nxt = miss_line;
    skip_nxt      = i_skip;
    fill_nxt      = fill_q;
    req_nxt       = req_q;
    we_nxt        = we_q;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    i_done_nxt    = 1'b0;
    d_done_nxt    = 1'b0;
    grant_d       = 1'b0;
    shared        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_miss || d_miss) begin
          // D normally wins; I is forced after MAX_I_WAIT consecutive D grants.
          grant_d       = d_miss && !(i_miss && skip_full);
          owner_d_nxt   = grant_d;
          miss_line_nxt = grant_d ? d_line : i_line;
          if (!grant_d)
            skip_nxt = '0;
          else if (i_miss && !skip_full)
            skip_nxt = i_skip + SKIP_W'(1);
          req_nxt = 1'b1;
          if (grant_d && d_dirty) begin
            state_nxt = ST_WB;
            we_nxt    = 1'b1;
            addr_nxt  = {wb_line, OFF_ZERO};
            wdata_nxt = d_wb_data;
          end else begin
            state_nxt = ST_FILL;
            addr_nxt  = {(grant_d ? d_line : i_line), OFF_ZERO};
          end
        end
      end
      ST_WB: begin
        if (mem.mem_ack) begin
          state_nxt = ST_FILL;
          we_nxt    = 1'b0;
          addr_nxt  = {miss_line, OFF_ZERO};
          wdata_nxt = '0;
        end
      end
      ST_FILL: begin
        if (mem.mem_ack) begin
          state_nxt = ST_RESP;
          req_nxt   = 1'b0;
          addr_nxt  = '0;
          fill_nxt  = mem.mem_rdata;
          // The other cache waiting on the same line is served by this fill;
          // a dirty D victim still needs its own write-back, so no sharing then.
          shared = owner_d ? (i_miss && (i_line == miss_line))
                           : (d_miss && !d_dirty && (d_line == miss_line));
          i_done_nxt = !owner_d || shared;
          d_done_nxt = owner_d || shared;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      owner_d   <= 1'b0;
      miss_line <= '0;
      i_skip    <= '0;
      fill_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner_d   <= owner_d_nxt;
      miss_line <= miss_line_nxt;
      i_skip    <= skip_nxt;
      fill_q    <= fill_nxt;
      req_q     <= req_nxt;
      we_q      <= we_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      i_done_q  <= i_done_nxt;
      d_done_q  <= d_done_nxt;
      busy_q    <= busy_nxt;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign fill_data     = fill_q;
  assign i_done        = i_done_q;
  assign d_done        = d_done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: a scripted memory responder plus
// hand-computed expectations for arbitration, write-back, sharing and reset.
module tb_cache_refill_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_miss, d_miss, d_dirty;
  logic [15:0] i_addr, d_addr, d_wb_addr;
  logic [63:0] d_wb_data;
  logic [63:0] fill_data;
  logic        i_done, d_done, busy;

  cache_refill_arbiter_if mem_bus ();

  cache_refill_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_miss    (i_miss),
    .i_addr    (i_addr),
    .d_miss    (d_miss),
    .d_addr    (d_addr),
    .d_dirty   (d_dirty),
    .d_wb_addr (d_wb_addr),
    .d_wb_data (d_wb_data),
    .fill_data (fill_data),
    .i_done    (i_done),
    .d_done    (d_done),
    .busy      (busy),
    .mem       (mem_bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0, n_rd = 0, n_wr = 0, n_idone = 0, n_ddone = 0;

  // Free-running event counters sampled at each edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_bus.mem_req && mem_bus.mem_ack) begin
      if (mem_bus.mem_we) n_wr <= n_wr + 1;
      else                n_rd <= n_rd + 1;
    end
    n_idone <= n_idone + (i_done ? 1 : 0);
    n_ddone <= n_ddone + (d_done ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for mem_req, capture the request, ack after lat further cycles.
  task automatic mem_serve(input int lat, input logic [63:0] rd,
                           output logic we, output logic [15:0] addr, output logic [63:0] wd);
    int w = 0;
    while (!mem_bus.mem_req && w < 40) begin
      tick();
      w++;
    end
    chk("req_seen", {63'd0, mem_bus.mem_req}, 64'd1);
    we   = mem_bus.mem_we;
    addr = mem_bus.mem_addr;
    wd   = mem_bus.mem_wdata;
    repeat (lat) tick();
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = rd;
    tick();
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic        we;
  logic [15:0] addr;
  logic [63:0] wd;
  int          g_cyc, rd0, wr0, id0, dd0;
  logic        exp_d [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    reset_n = 1'b0;
    i_miss = 0; d_miss = 0; d_dirty = 0;
    i_addr = '0; d_addr = '0; d_wb_addr = '0; d_wb_data = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_req",   {63'd0, mem_bus.mem_req}, 64'd0);
    chk("rst_we",    {63'd0, mem_bus.mem_we}, 64'd0);
    chk("rst_addr",  {48'd0, mem_bus.mem_addr}, 64'd0);
    chk("rst_wdata", mem_bus.mem_wdata, 64'd0);
    chk("rst_fill",  fill_data, 64'd0);
    chk("rst_flags", {60'd0, i_done, d_done, busy, 1'b0}, 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: I-only miss, ack 7 cycles after mem_req rises
    i_miss = 1; i_addr = 16'h0023;
    tick();
    g_cyc = cyc;
    chk("t1_busy", {63'd0, busy}, 64'd1);
    mem_serve(7, 64'h0000_6300_f81c_6200, we, addr, wd);
    chk("t1_we",    {63'd0, we}, 64'd0);
    chk("t1_addr",  {48'd0, addr}, 64'h20);
    chk("t1_idone", {63'd0, i_done}, 64'd1);
    chk("t1_ddone", {63'd0, d_done}, 64'd0);
    chk("t1_fill",  fill_data, 64'h0000_6300_f81c_6200);
    // done occupies cycle L+2 after the grant edge, i.e. visible L+1 edges later
    chk("t1_lat", 64'(cyc - g_cyc), 64'd8);
    i_miss = 0;
    tick();
    chk("t1_idone_off", {63'd0, i_done}, 64'd0);
    chk("t1_busy_off",  {63'd0, busy}, 64'd0);

    // 2: D dirty miss: write-back then fill
    id0 = n_idone;
    d_miss = 1; d_addr = 16'h0035; d_dirty = 1;
    d_wb_addr = 16'h0004; d_wb_data = 64'h1111_2222_3333_4444;
    tick();
    mem_serve(2, 64'hdead_beef_0000_0001, we, addr, wd);
    chk("t2_wb_we",   {63'd0, we}, 64'd1);
    chk("t2_wb_addr", {48'd0, addr}, 64'h4);
    chk("t2_wb_data", wd, 64'h1111_2222_3333_4444);
    mem_serve(1, 64'h5555_6666_7777_8888, we, addr, wd);
    chk("t2_rd_we",   {63'd0, we}, 64'd0);
    chk("t2_rd_addr", {48'd0, addr}, 64'h34);
    chk("t2_ddone",   {63'd0, d_done}, 64'd1);
    chk("t2_fill",    fill_data, 64'h5555_6666_7777_8888);
    d_miss = 0; d_dirty = 0;
    tick();
    chk("t2_no_idone", 64'(n_idone - id0), 64'd0);
    chk("t2_busy_off", {63'd0, busy}, 64'd0);

    // 3: both held; D keeps re-requesting. Expected D, D, I, D
    i_miss = 1; i_addr = 16'h0100;
    d_miss = 1; d_addr = 16'h0200;
    for (int g = 0; g < 4; g++) begin
      tick();
      mem_serve(g, 64'ha000 + 64'(g), we, addr, wd);
      chk($sformatf("t3_g%0d_ddone", g), {63'd0, d_done}, {63'd0, exp_d[g]});
      chk($sformatf("t3_g%0d_idone", g), {63'd0, i_done}, {63'd0, !exp_d[g]});
      chk($sformatf("t3_g%0d_addr", g), {48'd0, addr},
          exp_d[g] ? {48'd0, d_addr} : {48'd0, i_addr});
      if (exp_d[g]) d_addr = d_addr + 16'h0010;
      else          i_addr = 16'h0180;   // I re-requests; skip count must restart
      tick();
    end
    i_miss = 0; d_miss = 0;
    tick();
    chk("t3_busy_off", {63'd0, busy}, 64'd0);

    // 4: same line from both, clean -> one shared read
    rd0 = n_rd;
    i_miss = 1; i_addr = 16'h0041;
    d_miss = 1; d_addr = 16'h0042;
    tick();
    mem_serve(3, 64'h0123_4567_89ab_cdef, we, addr, wd);
    chk("t4_addr",  {48'd0, addr}, 64'h40);
    chk("t4_dones", {62'd0, i_done, d_done}, 64'd3);
    i_miss = 0; d_miss = 0;
    repeat (3) tick();
    chk("t4_reads", 64'(n_rd - rd0), 64'd1);
    chk("t4_busy",  {63'd0, busy}, 64'd0);

    // 5: reset during FILL, late ack ignored
    id0 = n_idone; dd0 = n_ddone;
    i_miss = 1; i_addr = 16'h0080;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; i_miss = 0;
    chk("t5_req",  {63'd0, mem_bus.mem_req}, 64'd0);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 64'hbad0_bad0_bad0_bad0;
    tick();
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    tick();
    chk("t5_busy2", {63'd0, busy}, 64'd0);
    chk("t5_fill",  fill_data, 64'd0);
    chk("t5_dones", 64'((n_idone - id0) + (n_ddone - dd0)), 64'd0);

    // 6: stray ack in IDLE, then minimum-latency transfer
    wr0 = n_wr; rd0 = n_rd;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 64'hffff_ffff_ffff_ffff;
    tick();
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    chk("t6_idle_busy", {63'd0, busy}, 64'd0);
    chk("t6_idle_fill", fill_data, 64'd0);
    d_miss = 1; d_addr = 16'h0abc; d_dirty = 0;
    tick();
    g_cyc = cyc;
    mem_serve(0, 64'h0f0f_1e1e_2d2d_3c3c, we, addr, wd);
    chk("t6_addr",  {48'd0, addr}, 64'h0abc);
    chk("t6_ddone", {63'd0, d_done}, 64'd1);
    chk("t6_fill",  fill_data, 64'h0f0f_1e1e_2d2d_3c3c);
    chk("t6_lat",   64'(cyc - g_cyc), 64'd1);
    d_miss = 0;
    tick();
    chk("t6_xfers", 64'((n_rd - rd0) + (n_wr - wr0)), 64'd1);
    chk("t6_busy_off", {63'd0, busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
